// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: valid/ready FIFO controller that drives an external 2-port ram (port0 write, port1 read)
// and hides the ram read latency behind a small skid buffer. Define FIFO_ALMOST_EN for almost_full/almost_empty.
module ram_fifo_ctrl #(
  parameter  int DATA  = 32,
  parameter  int DEPTH = 4,
  parameter  int RLAT  = 1,
  parameter  int AF_TH = DEPTH,
  parameter  int AE_TH = 1,
  localparam int SKID  = RLAT + 1,
  localparam int ADDR  = $clog2(DEPTH),
  localparam int CNTW  = $clog2(DEPTH + SKID + 1)
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA-1:0]      in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA-1:0]      out_data,
  output logic [CNTW-1:0]      count,
`ifdef FIFO_ALMOST_EN
  output logic                 almost_full,
  output logic                 almost_empty,
`endif
  output logic [1:0]           ram_en_,
  output logic [1:0]           ram_rw_,
  output logic [1:0][ADDR-1:0] ram_addr,
  output logic [1:0][DATA-1:0] ram_wdata,
  input  logic [1:0][DATA-1:0] ram_rdata
);

  localparam int              RCW      = ADDR + 1;
  localparam int              SIW      = (SKID > 1) ? $clog2(SKID) : 1;
  localparam logic [RCW-1:0]  RAM_FULL = RCW'(DEPTH);
  localparam logic [CNTW-1:0] SKID_CR  = CNTW'(SKID);
  localparam logic            RW_WRITE = 1'b0;
  localparam logic            RW_READ  = 1'b1;

  logic [ADDR-1:0] r_wptr;
  logic [ADDR-1:0] r_rptr;
  logic [RCW-1:0]  r_ramCnt;
  logic [RLAT-1:0] r_pipe;
  logic [DATA-1:0] r_skid [SKID];
  logic [SIW-1:0]  r_head;
  logic [SIW-1:0]  r_tail;
  logic [CNTW-1:0] r_skidCnt;

  logic [CNTW-1:0] w_inflight;
  logic [CNTW-1:0] w_credit;
  logic            w_push;
  logic            w_pop;
  logic            w_rdGo;
  logic            w_capture;
  logic            w_unused;

  function automatic logic [SIW-1:0] nextIdx(input logic [SIW-1:0] idx);
    return (idx == SIW'(SKID - 1)) ? '0 : idx + SIW'(1);
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RLAT; i++) w_inflight = w_inflight + CNTW'(r_pipe[i]);
  end

  assign in_ready  = reset_ && (r_ramCnt < RAM_FULL);
  assign w_push    = in_valid && in_ready;
  assign out_valid = (r_skidCnt != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_capture = r_pipe[RLAT-1];
  // A pop in the same cycle hands its skid slot straight back, so the prefetch loop keeps up at one per cycle.
  assign w_credit  = w_inflight + r_skidCnt - CNTW'(w_pop);
  assign w_rdGo    = (r_ramCnt != '0) && (w_credit < SKID_CR);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_ramCnt <= '0;
      r_pipe   <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + ADDR'(1);
      if (w_rdGo) r_rptr <= r_rptr + ADDR'(1);
      r_ramCnt <= r_ramCnt + RCW'(w_push) - RCW'(w_rdGo);
      r_pipe   <= (r_pipe << 1) | RLAT'(w_rdGo);
    end
  end

  // Skid buffer: the credit rule guarantees a free slot whenever the pipe tail delivers.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < SKID; i++) r_skid[i] <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_skidCnt <= '0;
    end else begin
      if (w_capture) begin
        r_skid[r_tail] <= ram_rdata[1];
        r_tail         <= nextIdx(r_tail);
      end
      if (w_pop) r_head <= nextIdx(r_head);
      r_skidCnt <= r_skidCnt + CNTW'(w_capture) - CNTW'(w_pop);
    end
  end

  assign out_data     = r_skid[r_head];
  assign count        = CNTW'(r_ramCnt) + w_inflight + r_skidCnt;
  assign ram_en_      = {~w_rdGo, ~w_push};
  assign ram_rw_      = {RW_READ, RW_WRITE};
  assign ram_addr[0]  = r_wptr;
  assign ram_addr[1]  = r_rptr;
  assign ram_wdata[0] = in_data;
  assign ram_wdata[1] = '0;
  assign w_unused     = ^ram_rdata[0];

`ifdef FIFO_ALMOST_EN
  logic [CNTW-1:0] w_countNext;
  logic            r_almostFull;
  logic            r_almostEmpty;

  assign w_countNext = count + CNTW'(w_push) - CNTW'(w_pop);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_almostFull  <= 1'b0;
      r_almostEmpty <= 1'b1;
    end else begin
      r_almostFull  <= (w_countNext >= CNTW'(AF_TH));
      r_almostEmpty <= (w_countNext <= CNTW'(AE_TH));
    end
  end

  assign almost_full  = r_almostFull;
  assign almost_empty = r_almostEmpty;
`endif

endmodule
